// File: rtl/i2s_pkg.sv
// i2s_pkg: shared types and sizing helpers for the I2S receive path.
//   rx_state_e   : deserializer FSM states (HUNT, LEFT, RIGHT)
//   SAMPLE_W_DEF : default bits captured per channel
//   frame_w()    : width of one stereo frame {left, right}
package i2s_pkg;

  localparam int SAMPLE_W_DEF = 16;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } rx_state_e;

  function automatic int frame_w(input int sample_w);
    return 2 * sample_w;
  endfunction

endpackage

// File: rtl/i2s_rx_sync.sv
// i2s_rx_sync: brings the three I2S pins into the clk domain.
// Each pin runs through a SYNC_STAGES flop chain. A registered single-cycle
// pulse marks each rising edge of the synced bit clock, and the synced word
// select and data are registered alongside it so all three line up in the
// rise cycle. Pin-to-rise latency is SYNC_STAGES+1 clk cycles.
//   clk, ar             : system clock, async active-low reset
//   bclk, lrclk, sd     : raw asynchronous I2S pins
//   rise                : one-cycle pulse per bclk rising edge
//   lr_bit, sd_bit      : word select / data valid in the rise cycle
module i2s_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic ar,
  input  logic bclk,
  input  logic lrclk,
  input  logic sd,
  output logic rise,
  output logic lr_bit,
  output logic sd_bit
);

  logic [SYNC_STAGES-1:0] bclk_q, lr_q, sd_q;
  logic                   bclk_prev;

  always_ff @(posedge clk or negedge ar) begin
    if (!ar) begin
      bclk_q    <= '0;
      lr_q      <= '0;
      sd_q      <= '0;
      bclk_prev <= 1'b0;
      rise      <= 1'b0;
      lr_bit    <= 1'b0;
      sd_bit    <= 1'b0;
    end else begin
      bclk_q    <= {bclk_q[SYNC_STAGES-2:0], bclk};
      lr_q      <= {lr_q[SYNC_STAGES-2:0], lrclk};
      sd_q      <= {sd_q[SYNC_STAGES-2:0], sd};
      bclk_prev <= bclk_q[SYNC_STAGES-1];
      // Registering the edge detect keeps rise, lr_bit and sd_bit aligned.
      rise      <= bclk_q[SYNC_STAGES-1] & ~bclk_prev;
      lr_bit    <= lr_q[SYNC_STAGES-1];
      sd_bit    <= sd_q[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/i2s_rx_deser.sv
// i2s_rx_deser: I2S receive deserializer, oversampled on clk.
// Recovers one {left, right} frame per LR period and offers it on a
// valid/ready port. A frame completing while the previous one is still
// unaccepted is dropped and flagged in the sticky overrun bit.
//   clk, ar                      : system clock (>= 8x bclk), async active-low reset
//   i2s_bclk, i2s_lrclk, i2s_sd  : asynchronous I2S pins (lrclk 0 = left)
//   out_data, out_valid          : frame {left, right}, held until accepted
//   out_ready                    : consumer accept
//   overrun, overrun_clr         : sticky drop flag and its single-cycle clear
module i2s_rx_deser
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W    = SAMPLE_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          ar,
  input  logic                          i2s_bclk,
  input  logic                          i2s_lrclk,
  input  logic                          i2s_sd,
  output logic [frame_w(SAMPLE_W)-1:0]  out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          overrun,
  input  logic                          overrun_clr
);

  localparam int CW = $clog2(SAMPLE_W + 1);

  logic                rise, lr_bit, sd_bit;
  logic                lr_prev;
  logic                boundary, frame_done, load, drop;
  logic [CW-1:0]       cnt;
  logic [SAMPLE_W-1:0] word, word_nxt, left_hold;
  rx_state_e           state;

  i2s_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .ar     (ar),
    .bclk   (i2s_bclk),
    .lrclk  (i2s_lrclk),
    .sd     (i2s_sd),
    .rise   (rise),
    .lr_bit (lr_bit),
    .sd_bit (sd_bit)
  );

  assign boundary = rise && (lr_bit != lr_prev);

  // Word including the bit sampled this rise. At a boundary this is the
  // final bit of the outgoing slot, so completion uses word_nxt, not word.
  // Once cnt saturates at SAMPLE_W no position matches and the bit is lost.
  always_comb begin
    word_nxt = word;
    for (int i = 0; i < SAMPLE_W; i++)
      if (cnt == CW'(SAMPLE_W - 1 - i)) word_nxt[i] = sd_bit;
  end

  assign frame_done = boundary && (state == RIGHT);
  assign load       = frame_done && (!out_valid || out_ready);
  assign drop       = frame_done && out_valid && !out_ready;

  always_ff @(posedge clk or negedge ar) begin
    if (!ar) begin
      state     <= HUNT;
      lr_prev   <= 1'b0;
      cnt       <= '0;
      word      <= '0;
      left_hold <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // Output register: a new frame takes priority over the accept that
      // frees the slot in the same cycle, so out_valid stays high.
      if (load) begin
        out_data  <= {left_hold, word_nxt};
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (drop)             overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;

      if (rise) begin
        lr_prev <= lr_bit;
        case (state)
          HUNT: begin
            // Only a right->left edge starts a frame; anything earlier is partial.
            if (boundary && !lr_bit) state <= LEFT;
            cnt  <= '0;
            word <= '0;
          end
          LEFT, RIGHT: begin
            if (boundary) begin
              if (state == LEFT) left_hold <= word_nxt;
              state <= (state == LEFT) ? RIGHT : LEFT;
              cnt   <= '0;
              word  <= '0;
            end else begin
              word <= word_nxt;
              if (cnt != CW'(SAMPLE_W)) cnt <= cnt + CW'(1);
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_deser.sv
module tb_i2s_rx_deser;
  import i2s_pkg::*;

  localparam int SW = 16;

  logic        clk = 1'b0, ar = 1'b1;
  logic        bclk = 1'b0, lrclk = 1'b0, sd = 1'b0;
  logic        out_ready = 1'b0, overrun_clr = 1'b0;
  logic [31:0] out_data;
  logic        out_valid, overrun;

  always #5 clk = ~clk;

  i2s_rx_deser #(.SAMPLE_W(SW), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .ar          (ar),
    .i2s_bclk    (bclk),
    .i2s_lrclk   (lrclk),
    .i2s_sd      (sd),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  int          n_vec = 0, n_err = 0;
  logic [31:0] sb[$];
  logic        rdy_base = 1'b0;
  logic        pend = 1'b0;   // last bit of the previous slot, sent at the next boundary

  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
    int          n;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted frame must match the oldest expectation.
  always @(negedge clk) begin
    if (ar && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_frame: got %h want none", out_data);
      end else begin
        check("frame", out_data, sb.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One bclk period = 8 clk: data changes with bclk low, rise after 4 clk.
  // pulse raises out_ready exactly for the cycle in which the DUT acts on
  // this rise (pin-to-rise latency is 3 clk).
  task automatic send_bit(input logic lr, input logic b, input logic pulse);
    step(); bclk = 1'b0; lrclk = lr; sd = b; out_ready = rdy_base;
    repeat (3) begin step(); out_ready = rdy_base; end
    step(); bclk = 1'b1;
    step(); step(); step(); out_ready = pulse ? 1'b1 : rdy_base;
  endtask

  // I2S slot of n bits, MSB first, one bclk late relative to lrclk.
  task automatic send_slot(input logic lr, input logic [31:0] val, input int n,
                           input logic push, input logic [31:0] exp, input logic pulse);
    if (push) sb.push_back(exp);
    send_bit(lr, pend, pulse);
    for (int i = 0; i < n - 1; i++) send_bit(lr, val[n-1-i], 1'b0);
    pend = val[0];
  endtask

  task automatic do_reset();
    ar = 1'b0;
    sb.delete();
    bclk = 1'b0; lrclk = 1'b0; sd = 1'b0;
    out_ready = 1'b0; overrun_clr = 1'b0; pend = 1'b0;
    repeat (3) step();
    ar = 1'b1;
    step();
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && sb.size() != 0; i++) begin step(); out_ready = rdy_base; end
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d frames outstanding, want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] prev;
    logic        have_prev;

    tbl[0] = '{32'h0000A5A5, 32'h00001234, 16, 32'hA5A51234};
    tbl[1] = '{32'hDEADBEEF, 32'h0F0F0000, 32, 32'hDEAD0F0F};
    tbl[2] = '{32'h00000ABC, 32'h00000123, 12, 32'hABC01230};
    tbl[3] = '{32'h0001FFFF, 32'h00000001, 17, 32'hFFFF0000};
    tbl[4] = '{32'h00008001, 32'h00007FFE, 16, 32'h80017FFE};

    // Reset state, checked before any clock edge has done work.
    #2 ar = 1'b0;
    #1;
    check("rst_data", out_data, 32'h0);
    check("rst_valid", {31'h0, out_valid}, 32'h0);
    check("rst_overrun", {31'h0, overrun}, 32'h0);

    // Table: back-to-back frames with various slot lengths, consumer always ready.
    do_reset();
    rdy_base = 1'b1;
    send_slot(1'b1, 32'h0, 16, 1'b0, 32'h0, 1'b0);
    have_prev = 1'b0;
    prev = '0;
    for (int v = 0; v < 5; v++) begin
      send_slot(1'b0, tbl[v].l, tbl[v].n, have_prev, prev, 1'b0);
      send_slot(1'b1, tbl[v].r, tbl[v].n, 1'b0, 32'h0, 1'b0);
      prev = tbl[v].exp;
      have_prev = 1'b1;
    end
    send_slot(1'b0, 32'h0, 1, 1'b1, prev, 1'b0);
    drain();

    // Backpressure: second frame dropped, first held, overrun sticky.
    do_reset();
    rdy_base = 1'b0;
    send_slot(1'b1, 32'h0, 16, 1'b0, 32'h0, 1'b0);
    send_slot(1'b0, 32'h1111, 16, 1'b0, 32'h0, 1'b0);
    send_slot(1'b1, 32'h2222, 16, 1'b0, 32'h0, 1'b0);
    send_slot(1'b0, 32'h3333, 16, 1'b1, 32'h11112222, 1'b0);
    send_slot(1'b1, 32'h4444, 16, 1'b0, 32'h0, 1'b0);
    send_slot(1'b0, 32'h0, 1, 1'b0, 32'h0, 1'b0);
    repeat (8) step();
    check("bp_valid", {31'h0, out_valid}, 32'h1);
    check("bp_data", out_data, 32'h11112222);
    check("bp_overrun", {31'h0, overrun}, 32'h1);
    step(); out_ready = 1'b1;
    step(); out_ready = 1'b0;
    step();
    check("bp_valid_after_accept", {31'h0, out_valid}, 32'h0);
    check("bp_overrun_holds", {31'h0, overrun}, 32'h1);
    check("bp_popped", sb.size(), 32'h0);
    overrun_clr = 1'b1;
    step(); overrun_clr = 1'b0;
    step();
    check("bp_overrun_clr", {31'h0, overrun}, 32'h0);

    // Accept of frame 1 in the very cycle frame 2 completes.
    do_reset();
    rdy_base = 1'b0;
    send_slot(1'b1, 32'h0, 16, 1'b0, 32'h0, 1'b0);
    send_slot(1'b0, 32'h5A5A, 16, 1'b0, 32'h0, 1'b0);
    send_slot(1'b1, 32'hC3C3, 16, 1'b0, 32'h0, 1'b0);
    send_slot(1'b0, 32'h0F0F, 16, 1'b1, 32'h5A5AC3C3, 1'b0);
    send_slot(1'b1, 32'hF0F0, 16, 1'b0, 32'h0, 1'b0);
    send_slot(1'b0, 32'h0, 1, 1'b1, 32'h0F0FF0F0, 1'b1);
    step(); out_ready = 1'b0;
    check("same_valid", {31'h0, out_valid}, 32'h1);
    check("same_data", out_data, 32'h0F0FF0F0);
    check("same_overrun", {31'h0, overrun}, 32'h0);
    check("same_first_popped", sb.size(), 32'h1);
    rdy_base = 1'b1;
    drain();

    // Reset released partway through a left slot: partial frame never emitted.
    do_reset();
    rdy_base = 1'b1;
    for (int i = 0; i < 7; i++) send_bit(1'b0, 1'($urandom_range(1, 0)), 1'b0);
    send_slot(1'b1, 32'hBEEF, 16, 1'b0, 32'h0, 1'b0);
    send_slot(1'b0, 32'h1357, 16, 1'b0, 32'h0, 1'b0);
    send_slot(1'b1, 32'h2468, 16, 1'b0, 32'h0, 1'b0);
    send_slot(1'b0, 32'h0, 1, 1'b1, 32'h13572468, 1'b0);
    drain();

    // Reset asserted mid-RIGHT with a frame pending: outputs clear at once.
    do_reset();
    rdy_base = 1'b0;
    send_slot(1'b1, 32'h0, 16, 1'b0, 32'h0, 1'b0);
    send_slot(1'b0, 32'h4321, 16, 1'b0, 32'h0, 1'b0);
    send_slot(1'b1, 32'h8765, 16, 1'b0, 32'h0, 1'b0);
    send_slot(1'b0, 32'h1111, 16, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1, 1'b0);
    check("pre_rst_data", out_data, 32'h43218765);
    #3 ar = 1'b0;
    #1;
    check("async_rst_data", out_data, 32'h0);
    check("async_rst_valid", {31'h0, out_valid}, 32'h0);
    check("async_rst_overrun", {31'h0, overrun}, 32'h0);
    do_reset();
    rdy_base = 1'b1;
    send_slot(1'b1, 32'h0, 16, 1'b0, 32'h0, 1'b0);
    send_slot(1'b0, 32'h9ABC, 16, 1'b0, 32'h0, 1'b0);
    send_slot(1'b1, 32'hDEF0, 16, 1'b0, 32'h0, 1'b0);
    send_slot(1'b0, 32'h0, 1, 1'b1, 32'h9ABCDEF0, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
